// File: rtl/front_panel_sequencer.sv
// Front-panel command sequencer: jams JMP/address or NOP bytes onto the CPU
// data-in path one byte per CPU read, and issues the deposit write strobe.
module front_panel_sequencer #(
   parameter int                    ADDR_BYTES = 2,
   parameter int                    DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] JMP_OPCODE = 'hC3,
   parameter logic [DATA_WIDTH-1:0] NOP_OPCODE = 'h00
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    rd,
   input  logic                    examine,
   input  logic                    examine_next,
   input  logic                    deposit,
   input  logic                    deposit_next,
   input  logic [8*ADDR_BYTES-1:0] addr_sw,
   input  logic [DATA_WIDTH-1:0]   data_sw,
   output logic [DATA_WIDTH-1:0]   jam_data,
   output logic                    jam_active,
   output logic [DATA_WIDTH-1:0]   deposit_out,
   output logic                    deposit_latch,
   output logic                    busy
);

   localparam int IDX_W = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ADDR_BYTES - 1);

   typedef enum logic [2:0] {
      IDLE, EXM_OP, EXM_ADDR, NXT_NOP, DEP_STROBE
   } state_t;

   state_t                         state_q, state_d;
   logic [IDX_W-1:0]               idx_q, idx_d, idx_nx;
   logic                           rd_q;
   logic [ADDR_BYTES-1:0][7:0]     addr_q, addr_d;
   logic [DATA_WIDTH-1:0]          data_q, data_d;
   logic                           dep_q, dep_d;
   logic [DATA_WIDTH-1:0]          jd_q, jd_d;
   logic                           ja_q, ja_d;
   logic [DATA_WIDTH-1:0]          do_q, do_d;
   logic                           dl_q, dl_d;
   logic                           rd_rise;

   // A read is consumed only on its rising edge; a held rd never advances.
   assign rd_rise = rd & ~rd_q;
   assign idx_nx  = idx_q + 1'b1;

   // Next-state and registered-output logic of the command sequencer.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      data_d  = data_q;
      dep_d   = dep_q;
      jd_d    = jd_q;
      ja_d    = ja_q;
      do_d    = do_q;
      dl_d    = 1'b0;
      case (state_q)
         IDLE: begin
            // Priority: examine > examine_next > deposit_next > deposit.
            if (examine) begin
               addr_d  = addr_sw;
               data_d  = data_sw;
               jd_d    = JMP_OPCODE;
               ja_d    = 1'b1;
               state_d = EXM_OP;
            end else if (examine_next || deposit_next) begin
               addr_d  = addr_sw;
               data_d  = data_sw;
               dep_d   = ~examine_next;
               jd_d    = NOP_OPCODE;
               ja_d    = 1'b1;
               state_d = NXT_NOP;
            end else if (deposit) begin
               addr_d  = addr_sw;
               data_d  = data_sw;
               do_d    = data_sw;
               state_d = DEP_STROBE;
            end
         end
         EXM_OP: begin
            if (rd_rise) begin
               idx_d   = '0;
               jd_d    = DATA_WIDTH'(addr_q[0]);
               state_d = EXM_ADDR;
            end
         end
         EXM_ADDR: begin
            if (rd_rise) begin
               if (idx_q == IDX_LAST) begin
                  jd_d    = '0;
                  ja_d    = 1'b0;
                  state_d = IDLE;
               end else begin
                  idx_d = idx_nx;
                  jd_d  = DATA_WIDTH'(addr_q[idx_nx]);
               end
            end
         end
         NXT_NOP: begin
            if (rd_rise) begin
               jd_d = '0;
               ja_d = 1'b0;
               if (dep_q) begin
                  do_d    = data_q;
                  state_d = DEP_STROBE;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DEP_STROBE: begin
            // Strobe in the clk after entry, leave once it has been issued.
            if (dl_q) state_d = IDLE;
            else      dl_d    = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset aborts any sequence and strobe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         rd_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         dep_q   <= 1'b0;
         jd_q    <= '0;
         ja_q    <= 1'b0;
         do_q    <= '0;
         dl_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rd_q    <= rd;
         addr_q  <= addr_d;
         data_q  <= data_d;
         dep_q   <= dep_d;
         jd_q    <= jd_d;
         ja_q    <= ja_d;
         do_q    <= do_d;
         dl_q    <= dl_d;
      end
   end

   assign jam_data      = jd_q;
   assign jam_active    = ja_q;
   assign deposit_out   = do_q;
   assign deposit_latch = dl_q;
   assign busy          = (state_q != IDLE);

endmodule
